muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_iter.sv | 30 +++
 rtl/muldiv_ctrl.sv | 133 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and widths for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned ACC_W         = 64;
    localparam int unsigned ITERS_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Magnitude of a two's-complement operand; pass-through when unsigned.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? DATA_W'(-v) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add multiply or restoring shift-subtract divide.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic              is_div,
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc_next_c
);

    logic [DATA_W:0]   sum_c;
    logic [DATA_W:0]   rem_c;
    logic [DATA_W-1:0] diff_c;
    logic              ge_c;

    // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, quotient}.
    always_comb begin
        sum_c  = {1'b0, acc[ACC_W-1:DATA_W]} + (acc[0] ? {1'b0, b} : '0);
        rem_c  = acc[ACC_W-1:DATA_W-1];
        ge_c   = (rem_c >= {1'b0, b});
        diff_c = DATA_W'(rem_c - {1'b0, b});
        if (is_div) begin
            acc_next_c = ge_c ? {diff_c, acc[DATA_W-2:0], 1'b1}
                              : {rem_c[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
        end else begin
            acc_next_c = {sum_c, acc[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller with fixed latency ITERS+FIX_CYCLES+1.
// Optional MULDIV_DIVZERO_EN: zero-divisor divides finish early and flag divzero.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned ITERS      = ITERS_DEFAULT,
    parameter int unsigned FIX_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_req,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              divzero
);

    localparam int unsigned CNT_W = $clog2(ITERS + FIX_CYCLES + 1);
`ifdef MULDIV_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    state_e            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc, acc_iter_c, fixed_c;
    logic [DATA_W-1:0] b_q;
    logic              is_div_q, neg_lo_q, neg_hi_q, dz_q;
    logic              is_div_c, is_signed_c, dz_start_c, last_iter_c, last_fix_c;

    assign is_div_c    = (op == OP_DIV) || (op == OP_DIVU);
    assign is_signed_c = (op == OP_MULT) || (op == OP_DIV);
    assign dz_start_c  = DZ_EN && is_div_c && (rt_val == '0);
    assign last_iter_c = (cnt == CNT_W'(ITERS - 1));
    assign last_fix_c  = (cnt == CNT_W'(FIX_CYCLES - 1));
    assign stall       = busy && (rd_req || start);

    muldiv_iter u_iter (
        .is_div     (is_div_q),
        .acc        (acc),
        .b          (b_q),
        .acc_next_c (acc_iter_c)
    );

    // Sign correction: divide fixes quotient and remainder separately, multiply the whole product.
    always_comb begin
        fixed_c = acc;
        if (is_div_q) begin
            if (neg_lo_q) fixed_c[DATA_W-1:0]     = DATA_W'(-acc[DATA_W-1:0]);
            if (neg_hi_q) fixed_c[ACC_W-1:DATA_W] = DATA_W'(-acc[ACC_W-1:DATA_W]);
        end else if (neg_lo_q) begin
            fixed_c = ACC_W'(-acc);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = dz_start_c ? DONE : RUN;
            RUN:     if (last_iter_c) state_next = FIX;
            FIX:     if (last_fix_c) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            divzero  <= 1'b0;
        end else begin
            busy    <= (state_next != IDLE);
            done    <= (state == DONE);
            divzero <= (state == DONE) && dz_q;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        is_div_q <= is_div_c;
                        dz_q     <= dz_start_c;
                        acc      <= {DATA_W'(0), mag(rs_val, is_signed_c)};
                        b_q      <= mag(rt_val, is_signed_c);
                        neg_lo_q <= is_signed_c && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
                        neg_hi_q <= is_signed_c && is_div_c && rs_val[DATA_W-1];
                    end
                end
                RUN: begin
                    acc <= acc_iter_c;
                    cnt <= last_iter_c ? '0 : cnt + CNT_W'(1);
                end
                FIX: begin
                    cnt <= last_fix_c ? '0 : cnt + CNT_W'(1);
                    if (last_fix_c) acc <= fixed_c;
                end
                DONE: begin
                    if (!dz_q) begin
                        hi <= acc[ACC_W-1:DATA_W];
                        lo <= acc[DATA_W-1:0];
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table plus multi-cycle corner sequences.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int LAT = 34;

    logic        clock = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0, rt_val = '0, wdata = '0;
    logic        mthi = 1'b0, mtlo = 1'b0, rd_req = 1'b0;
    logic        busy, stall, done, divzero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .rd_req  (rd_req),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .divzero (divzero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present an operation, let edge E0 accept it, then scramble the operand inputs.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clock);
        #1;
        start  = 1'b0;
        op     = 2'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic wait_done(input int maxc, output int lat);
        lat = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
        vecs[9]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[10] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

        // Asynchronous reset, checked before any clock edge.
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_divzero", 32'(divzero), 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
            wait_done(60, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'h0);
            chk($sformatf("v%0d_divzero", i), 32'(divzero), 32'h0);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
        end

        // rd_req from cycle 5 of a MULT: stall through cycle 33, released in the done cycle.
        launch(OP_MULT, 32'h00000006, 32'hFFFFFFF9);
        bad = 0;
        for (int k = 1; k <= 33; k++) begin
            @(posedge clock);
            #1;
            if (k >= 5) rd_req = 1'b1;
            #1;
            if (k >= 5 && stall !== 1'b1) bad++;
            if (done !== 1'b0) bad++;
            if (lo !== 32'h00000002) bad++;
        end
        chk("stall_run_errors", 32'(bad), 32'h0);
        @(posedge clock);
        #2;
        chk("stall_done_pulse", 32'(done), 32'h1);
        chk("stall_released", 32'(stall), 32'h0);
        chk("stall_hi", hi, 32'hFFFFFFFF);
        chk("stall_lo", lo, 32'hFFFFFFD6);
        rd_req = 1'b0;

        // Start held while busy is not accepted until the unit returns to IDLE.
        @(negedge clock);
        launch(OP_DIVU, 32'd100, 32'd7);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            #1;
            if (k == 10) begin
                start  = 1'b1;
                op     = OP_MULTU;
                rs_val = 32'd6;
                rt_val = 32'd7;
                #1;
                chk("start_busy_stall", 32'(stall), 32'h1);
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("held_first_latency", 32'(lat), 32'(LAT));
        chk("held_first_lo", lo, 32'd14);
        chk("held_first_hi", hi, 32'd2);
        chk("held_idle_stall", 32'(stall), 32'h0);
        @(posedge clock);
        #1;
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        wait_done(60, lat);
        chk("held_second_latency", 32'(lat), 32'(LAT));
        chk("held_second_lo", lo, 32'd42);
        chk("held_second_hi", hi, 32'd0);

        // mtlo ignored while running, applied when idle; move plus start in IDLE.
        launch(OP_MULTU, 32'd3, 32'd4);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            #1;
            if (k == 5) begin
                mtlo  = 1'b1;
                wdata = 32'h1234;
            end
            if (k == 6) begin
                mtlo = 1'b0;
                chk("mtlo_busy_ignored", lo, 32'd42);
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("mtlo_run_latency", 32'(lat), 32'(LAT));
        chk("mtlo_run_lo", lo, 32'd12);
        @(posedge clock);
        #1;
        mtlo  = 1'b1;
        wdata = 32'h1234;
        @(posedge clock);
        #1;
        mtlo = 1'b0;
        chk("mtlo_idle", lo, 32'h1234);
        mthi  = 1'b1;
        wdata = 32'h55;
        launch(OP_MULTU, 32'd2, 32'd2);
        mthi = 1'b0;
        chk("mthi_with_start_hi", hi, 32'h55);
        chk("mthi_with_start_busy", 32'(busy), 32'h1);
        wait_done(60, lat);
        chk("mthi_with_start_latency", 32'(lat), 32'(LAT));
        chk("mthi_with_start_result_hi", hi, 32'h0);
        chk("mthi_with_start_result_lo", lo, 32'h4);

        // Zero divisor.
        @(posedge clock);
        #1;
        mthi  = 1'b1;
        wdata = 32'h77;
        @(posedge clock);
        #1;
        mthi = 1'b0;
        chk("mthi_idle", hi, 32'h77);
        launch(OP_DIV, 32'd5, 32'd0);
        wait_done(60, lat);
`ifdef MULDIV_DIVZERO_EN
        chk("dz_latency", 32'(lat), 32'h1);
        chk("dz_flag", 32'(divzero), 32'h1);
        chk("dz_hi_kept", hi, 32'h77);
        chk("dz_lo_kept", lo, 32'h4);
`else
        chk("dz_latency", 32'(lat), 32'(LAT));
        chk("dz_flag", 32'(divzero), 32'h0);
        chk("dz_hi", hi, 32'd5);
        chk("dz_lo", lo, 32'hFFFFFFFF);
`endif

        // Reset in the middle of RUN aborts without an update; next op runs full latency.
        @(posedge clock);
        #1;
        launch(OP_MULT, 32'd6, 32'd7);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        launch(OP_DIVU, 32'd9, 32'd3);
        wait_done(60, lat);
        chk("after_abort_latency", 32'(lat), 32'(LAT));
        chk("after_abort_lo", lo, 32'd3);
        chk("after_abort_hi", hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
